// File: rtl/array_read_streamer.sv
// Streams a contiguous, wrap-around range of the array's combinational read port
// out as a valid/ready word stream, one word per cycle when not stalled.
module array_read_streamer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR-1:0]  base_addr,
    input  logic [ADDR:0]    count,
    output logic [ADDR-1:0]  read_addr,
    input  logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1);
    localparam logic [ADDR-1:0] ADDR_TOP = ADDR'(DEPTH - 1);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR + 1)'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state, state_nxt;
    logic [ADDR:0] remaining;
    logic          accept, empty_req, load, xfer, finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        empty_req = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
        xfer      = out_valid && out_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        accept    = 1'b1;
                        state_nxt = STREAM;
                    end else begin
                        empty_req = 1'b1;
                    end
                end
            end
            STREAM: begin
                // Refill the output register whenever it is empty or draining this edge.
                load   = (!out_valid || out_ready) && (remaining != '0);
                finish = xfer && out_last;
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= empty_req || finish;
            if (accept) begin
                read_addr <= base_addr;
                remaining <= count;
            end
            if (load) begin
                out_data  <= read_data;
                out_valid <= 1'b1;
                out_last  <= (remaining == CNT_ONE);
                remaining <= remaining - CNT_ONE;
                // Wrap at DEPTH so non-power-of-two arrays never see an out-of-range address.
                read_addr <= (read_addr == ADDR_TOP) ? '0 : read_addr + ADDR_ONE;
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign busy = (state == STREAM);

endmodule

// File: tb/tb_array_read_streamer.sv
// Randomized and directed checks of array_read_streamer against a queue-based
// model of the expected word stream, on DEPTH=4 and DEPTH=5 instances.
module tb_array_read_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   sel;

    logic       a_start, a_ovalid, a_oready, a_olast, a_busy, a_done;
    logic [1:0] a_base, a_raddr;
    logic [2:0] a_count;
    logic [7:0] a_rdata, a_odata;

    logic       b_start, b_ovalid, b_oready, b_olast, b_busy, b_done;
    logic [2:0] b_base, b_raddr;
    logic [3:0] b_count;
    logic [7:0] b_rdata, b_odata;

    logic [7:0] mem_a [4];
    logic [7:0] mem_b [5];

    assign a_rdata = mem_a[a_raddr];
    assign b_rdata = (b_raddr < 3'd5) ? mem_b[b_raddr] : 8'h00;

    array_read_streamer #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base), .count(a_count),
        .read_addr(a_raddr), .read_data(a_rdata), .out_data(a_odata), .out_valid(a_ovalid),
        .out_ready(a_oready), .out_last(a_olast), .busy(a_busy), .done(a_done)
    );

    array_read_streamer #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .count(b_count),
        .read_addr(b_raddr), .read_data(b_rdata), .out_data(b_odata), .out_valid(b_ovalid),
        .out_ready(b_oready), .out_last(b_olast), .busy(b_busy), .done(b_done)
    );

    logic       m_valid, m_last, m_busy, m_done;
    logic [7:0] m_data;
    int         m_raddr;

    always_comb begin
        if (sel == 1) begin
            m_valid = b_ovalid; m_last = b_olast; m_busy = b_busy; m_done = b_done;
            m_data  = b_odata;  m_raddr = int'(b_raddr);
        end else begin
            m_valid = a_ovalid; m_last = a_olast; m_busy = a_busy; m_done = a_done;
            m_data  = a_odata;  m_raddr = int'(a_raddr);
        end
    end

    task automatic drive(input logic st, input int base, input int cnt);
        if (sel == 1) begin
            b_start = st; b_base = 3'(base); b_count = 4'(cnt);
        end else begin
            a_start = st; a_base = 2'(base); a_count = 3'(cnt);
        end
    endtask

    task automatic set_ready(input logic r);
        if (sel == 1) b_oready = r;
        else          a_oready = r;
    endtask

    task automatic load_default_mem();
        for (int i = 0; i < 4; i++) mem_a[i] = 8'(i * 8'h22);
        for (int i = 0; i < 5; i++) mem_b[i] = 8'(i * 8'h22);
    endtask

    // patlen>0: ready follows pat bits then stays 1; patlen==0: always 1; patlen<0: random.
    // poke>=0: pulse start with other arguments on that cycle of the burst.
    task automatic run_burst(input int base, input int cnt, input logic [31:0] pat,
                             input int patlen, input int poke);
        int         d, got, loads;
        logic [7:0] exp_q[$];
        logic       stalled, hl, r;
        logic [7:0] hd;
        d = (sel == 1) ? 5 : 4;
        exp_q = {};
        for (int i = 0; i < cnt; i++)
            exp_q.push_back((sel == 1) ? mem_b[(base + i) % d] : mem_a[(base + i) % d]);
        @(negedge clk);
        drive(1'b1, base, cnt);
        @(negedge clk);
        drive(1'b0, base, cnt);
        if (cnt == 0) begin
            total++;
            if (m_done !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_count: done=%b busy=%b valid=%b want 1 0 0", m_done, m_busy, m_valid);
            end
            @(negedge clk);
            total++;
            if (m_done !== 1'b0 || m_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_count_drop: done=%b valid=%b want 0 0", m_done, m_valid);
            end
            return;
        end
        got = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
        for (int cyc = 0; cyc < 300 && got < cnt; cyc++) begin
            loads = got + (m_valid ? 1 : 0);
            total++;
            if (m_raddr !== (base + loads) % d) begin
                bad++;
                $display("FAIL read_addr: got %0d want %0d (cyc %0d)", m_raddr, (base + loads) % d, cyc);
            end
            total++;
            if (m_busy !== 1'b1 || m_done !== 1'b0) begin
                bad++;
                $display("FAIL busy_done: busy=%b done=%b want 1 0 (cyc %0d)", m_busy, m_done, cyc);
            end
            if (stalled) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== hd || m_last !== hl) begin
                    bad++;
                    $display("FAIL hold: valid=%b data=%h last=%b want 1 %h %b", m_valid, m_data, m_last, hd, hl);
                end
            end
            if (cyc < patlen)     r = pat[cyc];
            else if (patlen < 0)  r = 1'($urandom_range(0, 1));
            else                  r = 1'b1;
            if (cyc == poke) drive(1'b1, (base + 1) % d, 1);
            else             drive(1'b0, base, cnt);
            set_ready(r);
            if (m_valid && r) begin
                total++;
                if (m_data !== exp_q[got] || m_last !== (got == cnt - 1)) begin
                    bad++;
                    $display("FAIL word%0d: data=%h last=%b want %h %b", got, m_data, m_last,
                             exp_q[got], (got == cnt - 1));
                end
                got++;
            end
            stalled = m_valid && !r;
            hd = m_data; hl = m_last;
            @(negedge clk);
        end
        drive(1'b0, base, cnt);
        total++;
        if (got != cnt) begin
            bad++;
            $display("FAIL timeout: got %0d words want %0d", got, cnt);
        end
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL end: done=%b busy=%b valid=%b want 1 0 0", m_done, m_busy, m_valid);
        end
        total++;
        if (m_raddr !== (base + cnt) % d) begin
            bad++;
            $display("FAIL end_addr: got %0d want %0d", m_raddr, (base + cnt) % d);
        end
        set_ready(1'b0);
        @(negedge clk);
        total++;
        if (m_done !== 1'b0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_drop: done=%b valid=%b want 0 0", m_done, m_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({a_raddr, a_odata, a_ovalid, a_olast, a_busy, a_done} !== '0 ||
            {b_raddr, b_odata, b_ovalid, b_olast, b_busy, b_done} !== '0) begin
            bad++;
            $display("FAIL reset: a=%h b=%h want 0",
                     {a_raddr, a_odata, a_ovalid, a_olast, a_busy, a_done},
                     {b_raddr, b_odata, b_ovalid, b_olast, b_busy, b_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        sel = 0;
        run_burst(0, 4, 32'h0, 0, -1);
    endtask

    task automatic test_wrap();
        sel = 0;
        run_burst(3, 3, 32'h0, 0, -1);
    endtask

    task automatic test_backpressure();
        sel = 0;
        run_burst(0, 4, 32'h69, 7, -1);
    endtask

    task automatic test_count_zero();
        sel = 0;
        run_burst(2, 0, 32'h0, 0, -1);
    endtask

    task automatic test_start_busy();
        sel = 0;
        run_burst(0, 4, 32'h69, 7, 2);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        @(negedge clk);
        drive(1'b1, 0, 4);
        set_ready(1'b1);
        @(negedge clk);
        drive(1'b0, 0, 4);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h22) begin
            bad++;
            $display("FAIL pre_reset: valid=%b data=%h want 1 22", m_valid, m_data);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({a_raddr, a_odata, a_ovalid, a_olast, a_busy, a_done} !== '0) begin
            bad++;
            $display("FAIL mid_reset: outputs=%h want 0", {a_raddr, a_odata, a_ovalid, a_olast, a_busy, a_done});
        end
        #1 rst = 1'b0;
        run_burst(1, 2, 32'h0, 0, -1);
    endtask

    task automatic test_depth5();
        sel = 1;
        run_burst(3, 4, 32'h0, 0, -1);
        run_burst(4, 2, 32'h0, 0, -1);
    endtask

    task automatic test_random();
        int d, base, cnt;
        for (int it = 0; it < 16; it++) begin
            sel = int'($urandom_range(0, 1));
            d = (sel == 1) ? 5 : 4;
            for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
            for (int i = 0; i < 5; i++) mem_b[i] = 8'($urandom);
            base = int'($urandom_range(0, d - 1));
            cnt  = int'($urandom_range(0, (sel == 1) ? 12 : 7));
            run_burst(base, cnt, 32'h0, -1, (it % 3 == 0) ? 1 : -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        sel = 0;
        a_start = 1'b0; a_base = '0; a_count = '0; a_oready = 1'b0;
        b_start = 1'b0; b_base = '0; b_count = '0; b_oready = 1'b0;
        load_default_mem();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_count_zero();
        test_start_busy();
        test_reset_mid();
        test_depth5();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
